pc_source_unit: RTL and testbench
=================================

Name: pc_source_unit

Overview:
Parametrised next-PC block for the multicycle CPU. It replaces the fixed 5-input PC-source selector and the PC register with one unit. The unit holds N_SRC packed target sources and the PC register itself. It adds conditional-branch write qualification and detection of illegal selects and misaligned targets. It provides a one-cycle trap sequence that loads an exception vector. It sits between the control FSM/datapath sources and the instruction-memory address bus.

Parameters:
DATA_W, 32, width of PC and of every source
N_SRC, 5, number of valid sources; legal range 1..2**SEL_W
SEL_W, 3, width of the select input
RESET_PC, 32'h0000_0000, PC value on reset
EXC_VECTOR, 32'h0000_00FD, PC loaded by the trap sequence
CNT_W, 16, width of the saturating commit counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
src_flat  in  N_SRC*DATA_W  packed sources; source k is at bits [k*DATA_W +: DATA_W]; k=0 ULA, 1 AluOut, 2 concatenated jump, 3 MDR, 4 EPC
sel  in  SEL_W  source select
pc_write  in  1  unconditional PC write request
pc_write_cond  in  1  conditional PC write request (branch)
cond_flag  in  1  branch condition (ALU zero or its complement, chosen upstream)
pc_out  out  DATA_W  current PC (registered)
pc_prev  out  DATA_W  PC value before the most recent update
bad_target  out  DATA_W  offending value captured at the last trap
cause  out  2  0 none, 1 illegal select, 2 misaligned target
trap  out  1  high for exactly the cycle the FSM is in TRAP
commit  out  1  one-cycle pulse after each successful PC update
commit_cnt  out  CNT_W  saturating count of successful updates

Behaviour:
- Reset (asynchronous) sets: pc_out=RESET_PC, pc_prev=RESET_PC, bad_target=0, cause=0, trap=0, commit=0, commit_cnt=0, state=RUN. Reset asserted while in TRAP aborts the trap; the vector is not loaded.
- Write enable: wen = pc_write | (pc_write_cond & cond_flag). If both requests are high, the unconditional write wins, so wen=1.
- target = source[sel] when sel < N_SRC; otherwise the select is illegal.
- FSM states: RUN and TRAP. Only RUN accepts writes.
- RUN with wen=0: all registers hold; commit=0.
- RUN, wen=1, sel >= N_SRC:
  - pc_out holds.
  - bad_target <= pc_out; cause <= 1.
  - next state TRAP.
- RUN, wen=1, legal select, misaligned target (alignment check enabled and target[1:0] != 0):
  - pc_out holds.
  - bad_target <= target; cause <= 2.
  - next state TRAP.
- RUN, wen=1, legal select, aligned target:
  - pc_prev <= pc_out; pc_out <= target.
  - commit=1 in the following cycle.
  - commit_cnt increments and saturates at all-ones.
  - cause is unchanged.
- TRAP (exactly one cycle):
  - trap=1 is a Moore output of this state.
  - All write inputs are ignored.
  - At the clock edge leaving TRAP: pc_prev <= pc_out, pc_out <= EXC_VECTOR, next state RUN.
  - commit is not pulsed and commit_cnt does not change.
- cause and bad_target are sticky until the next trap or reset.
- Latency: accepted write to new pc_out is 1 cycle. Trapping write to pc_out=EXC_VECTOR is 2 cycles.
- No arithmetic other than the counter. Sources are used as-is; width is DATA_W throughout.

Optional Feature:
PC_SOURCE_ALIGN_CHECK_EN
- Defined: the misaligned-target check is active, as described in Behaviour.
- Undefined: there is no alignment check. Any legal-select target is committed, and cause never takes the value 2. Illegal-select trapping remains in both builds.

Decomposition:
- Package pc_source_pkg contains:
  - state enum {RUN, TRAP}
  - cause constants CAUSE_NONE=0, CAUSE_ILLEGAL_SEL=1, CAUSE_MISALIGN=2
  - select constants SEL_ULA=0, SEL_ALUOUT=1, SEL_CONCAT=2, SEL_MDR=3, SEL_EPC=4
- One sub-module, pc_source_mux: combinational N_SRC-way selector with outputs target and sel_valid.
- The top level holds the FSM, the registers and the counter.

Test Plan:
- Reset, then pc_write=1, sel=1, AluOut=32'h0000_0040 -> next cycle pc_out=32'h40, pc_prev=0, commit=1, commit_cnt=1.
- pc_write_cond=1, cond_flag=0, sel=0, ULA=32'h80 -> pc_out unchanged, commit=0. Repeat with cond_flag=1 -> pc_out=32'h80.
- pc_out=32'h80, pc_write=1, sel=7 -> trap=1 the next cycle, cause=1, bad_target=32'h80. One cycle later pc_out=32'hFD, pc_prev=32'h80, commit_cnt unchanged.
- With PC_SOURCE_ALIGN_CHECK_EN defined: pc_write=1, sel=3, MDR=32'h0000_0102 -> trap, cause=2, bad_target=32'h102, then pc_out=32'hFD. With the macro undefined: pc_out=32'h102.
- Assert reset during the TRAP cycle -> pc_out=0, trap=0 immediately; no vector is loaded after reset releases.
- With CNT_W=2, perform 5 good writes -> commit_cnt stops at 3.

Source files
------------

// File: rtl/pc_source_pkg.sv
// Shared types and constants for the next-PC unit: FSM states, trap causes,
// and the source select encodings.
package pc_source_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

    localparam logic [1:0] CAUSE_NONE        = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL_SEL = 2'd1;
    localparam logic [1:0] CAUSE_MISALIGN    = 2'd2;

    localparam int SEL_ULA    = 0;
    localparam int SEL_ALUOUT = 1;
    localparam int SEL_CONCAT = 2;
    localparam int SEL_MDR    = 3;
    localparam int SEL_EPC    = 4;

endpackage

// File: rtl/pc_source_mux.sv
// Combinational N_SRC-way selector over the packed source bus.
// sel_valid is low when sel addresses a source that does not exist.
module pc_source_mux
    import pc_source_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_SRC  = 5,
    parameter int SEL_W  = 3
) (
    input  logic [N_SRC*DATA_W-1:0] src_flat,
    input  logic [SEL_W-1:0]        sel,
    output logic [DATA_W-1:0]       target,
    output logic                    sel_valid
);

    assign sel_valid = (int'(sel) < N_SRC);

    always_comb begin
        target = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (int'(sel) == k) begin
                target = src_flat[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/pc_source_unit.sv
// Next-PC unit: source select, PC register, branch qualification and a
// one-cycle trap to EXC_VECTOR. Define PC_SOURCE_ALIGN_CHECK_EN to trap on targets with nonzero low bits.
//
// state | meaning
// RUN   | accepts PC writes; illegal select or misaligned target enters TRAP
// TRAP  | one cycle, writes ignored; leaving it loads EXC_VECTOR into the PC
module pc_source_unit
    import pc_source_pkg::*;
#(
    parameter int                 DATA_W     = 32,
    parameter int                 N_SRC      = 5,
    parameter int                 SEL_W      = 3,
    parameter logic [DATA_W-1:0]  RESET_PC   = 32'h0000_0000,
    parameter logic [DATA_W-1:0]  EXC_VECTOR = 32'h0000_00FD,
    parameter int                 CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_SRC*DATA_W-1:0] src_flat,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    pc_write,
    input  logic                    pc_write_cond,
    input  logic                    cond_flag,
    output logic [DATA_W-1:0]       pc_out,
    output logic [DATA_W-1:0]       pc_prev,
    output logic [DATA_W-1:0]       bad_target,
    output logic [1:0]              cause,
    output logic                    trap,
    output logic                    commit,
    output logic [CNT_W-1:0]        commit_cnt
);

    state_t            state;
    logic [DATA_W-1:0] target;
    logic              sel_valid;
    logic              wen;
    logic              misaligned;

    pc_source_mux #(
        .DATA_W (DATA_W),
        .N_SRC  (N_SRC),
        .SEL_W  (SEL_W)
    ) u_mux (
        .src_flat  (src_flat),
        .sel       (sel),
        .target    (target),
        .sel_valid (sel_valid)
    );

    assign wen = pc_write | (pc_write_cond & cond_flag);

`ifdef PC_SOURCE_ALIGN_CHECK_EN
    assign misaligned = (target[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            pc_out     <= RESET_PC;
            pc_prev    <= RESET_PC;
            bad_target <= '0;
            cause      <= CAUSE_NONE;
            trap       <= 1'b0;
            commit     <= 1'b0;
            commit_cnt <= '0;
        end else begin
            commit <= 1'b0;
            case (state)
                RUN: begin
                    if (wen) begin
                        if (!sel_valid) begin
                            bad_target <= pc_out;
                            cause      <= CAUSE_ILLEGAL_SEL;
                            trap       <= 1'b1;
                            state      <= TRAP;
                        end else if (misaligned) begin
                            bad_target <= target;
                            cause      <= CAUSE_MISALIGN;
                            trap       <= 1'b1;
                            state      <= TRAP;
                        end else begin
                            pc_prev <= pc_out;
                            pc_out  <= target;
                            commit  <= 1'b1;
                            if (commit_cnt != {CNT_W{1'b1}}) begin
                                commit_cnt <= commit_cnt + CNT_W'(1);
                            end
                        end
                    end
                end
                TRAP: begin
                    pc_prev <= pc_out;
                    pc_out  <= EXC_VECTOR;
                    trap    <= 1'b0;
                    state   <= RUN;
                end
                default: begin
                    trap  <= 1'b0;
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_source_unit.sv
// Directed bench for pc_source_unit with CNT_W=2 so counter saturation is
// reachable; expectations follow the PC_SOURCE_ALIGN_CHECK_EN setting.
module tb_pc_source_unit;

    localparam int DATA_W = 32;
    localparam int N_SRC  = 5;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [DATA_W-1:0]       src [N_SRC];
    logic [N_SRC*DATA_W-1:0] src_flat;
    logic [SEL_W-1:0]        sel;
    logic                    pc_write;
    logic                    pc_write_cond;
    logic                    cond_flag;
    logic [DATA_W-1:0]       pc_out;
    logic [DATA_W-1:0]       pc_prev;
    logic [DATA_W-1:0]       bad_target;
    logic [1:0]              cause;
    logic                    trap;
    logic                    commit;
    logic [CNT_W-1:0]        commit_cnt;

    int passed = 0;
    int total  = 0;
    int exp_cnt;
    logic [DATA_W-1:0] exp_pc;
    logic [1:0]        exp_cause;
    logic [DATA_W-1:0] exp_bad;

    assign src_flat = {src[4], src[3], src[2], src[1], src[0]};

    always #5 clk = ~clk;

    pc_source_unit #(
        .DATA_W     (DATA_W),
        .N_SRC      (N_SRC),
        .SEL_W      (SEL_W),
        .RESET_PC   (32'h0000_0000),
        .EXC_VECTOR (32'h0000_00FD),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .src_flat      (src_flat),
        .sel           (sel),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .cond_flag     (cond_flag),
        .pc_out        (pc_out),
        .pc_prev       (pc_prev),
        .bad_target    (bad_target),
        .cause         (cause),
        .trap          (trap),
        .commit        (commit),
        .commit_cnt    (commit_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        cond_flag     = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        sel = '0;
        for (int i = 0; i < N_SRC; i++) src[i] = '0;
        #12;
        check("rst_pc", pc_out, 32'h0);
        check("rst_prev", pc_prev, 32'h0);
        check("rst_bad", bad_target, 32'h0);
        check("rst_cause", 32'(cause), 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_commit", 32'(commit), 32'd0);
        check("rst_cnt", 32'(commit_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // unconditional write from AluOut
        src[1] = 32'h0000_0040;
        sel = 3'd1;
        pc_write = 1'b1;
        step();
        idle_inputs();
        check("w1_pc", pc_out, 32'h40);
        check("w1_prev", pc_prev, 32'h0);
        check("w1_commit", 32'(commit), 32'd1);
        check("w1_cnt", 32'(commit_cnt), 32'd1);
        step();
        check("idle_commit", 32'(commit), 32'd0);
        check("idle_pc", pc_out, 32'h40);

        // branch not taken then taken
        src[0] = 32'h0000_0080;
        sel = 3'd0;
        pc_write_cond = 1'b1;
        cond_flag = 1'b0;
        step();
        check("bnt_pc", pc_out, 32'h40);
        check("bnt_commit", 32'(commit), 32'd0);
        cond_flag = 1'b1;
        step();
        idle_inputs();
        check("bt_pc", pc_out, 32'h80);
        check("bt_prev", pc_prev, 32'h40);
        check("bt_cnt", 32'(commit_cnt), 32'd2);

        // illegal select; inputs during TRAP must be ignored
        sel = 3'd7;
        pc_write = 1'b1;
        step();
        sel = 3'd1;
        check("ill_trap", 32'(trap), 32'd1);
        check("ill_cause", 32'(cause), 32'd1);
        check("ill_bad", bad_target, 32'h80);
        check("ill_pc_hold", pc_out, 32'h80);
        check("ill_commit", 32'(commit), 32'd0);
        step();
        idle_inputs();
        check("vec_pc", pc_out, 32'hFD);
        check("vec_prev", pc_prev, 32'h80);
        check("vec_trap", 32'(trap), 32'd0);
        check("vec_commit", 32'(commit), 32'd0);
        check("vec_cnt", 32'(commit_cnt), 32'd2);

        // first out-of-range select value
        sel = 3'd5;
        pc_write = 1'b1;
        step();
        idle_inputs();
        check("sel5_trap", 32'(trap), 32'd1);
        check("sel5_bad", bad_target, 32'hFD);
        step();
        check("sel5_pc", pc_out, 32'hFD);

        // target with nonzero low bits from MDR
        src[3] = 32'h0000_0102;
        sel = 3'd3;
        pc_write = 1'b1;
        step();
        idle_inputs();
        exp_cnt = 2;
`ifdef PC_SOURCE_ALIGN_CHECK_EN
        check("mis_trap", 32'(trap), 32'd1);
        check("mis_cause", 32'(cause), 32'd2);
        check("mis_bad", bad_target, 32'h102);
        step();
        check("mis_pc", pc_out, 32'hFD);
        exp_cause = 2'd2;
        exp_bad   = 32'h102;
`else
        check("mis_trap", 32'(trap), 32'd0);
        check("mis_pc", pc_out, 32'h102);
        check("mis_prev", pc_prev, 32'hFD);
        check("mis_cause", 32'(cause), 32'd1);
        exp_cnt   = 3;
        exp_cause = 2'd1;
        exp_bad   = 32'hFD;
`endif
        check("mis_cnt", 32'(commit_cnt), 32'(exp_cnt));

        // both requests high with cond_flag low: unconditional wins; cause sticky
        src[4] = 32'h0000_0200;
        sel = 3'd4;
        pc_write = 1'b1;
        pc_write_cond = 1'b1;
        cond_flag = 1'b0;
        step();
        idle_inputs();
        check("both_pc", pc_out, 32'h200);
        check("sticky_cause", 32'(cause), 32'(exp_cause));
        check("sticky_bad", bad_target, exp_bad);
        check("sat_cnt", 32'(commit_cnt), 32'd3);

        // reset asserted during TRAP aborts the vector load
        sel = 3'd6;
        pc_write = 1'b1;
        step();
        idle_inputs();
        check("rt_trap", 32'(trap), 32'd1);
        reset = 1'b1;
        #1;
        check("rt_pc", pc_out, 32'h0);
        check("rt_trapclr", 32'(trap), 32'd0);
        check("rt_cause", 32'(cause), 32'd0);
        step();
        @(negedge clk);
        reset = 1'b0;
        step();
        check("rt_after_pc", pc_out, 32'h0);
        check("rt_after_trap", 32'(trap), 32'd0);

        // five good writes: counter saturates at 3
        exp_cnt = 0;
        for (int i = 1; i <= 5; i++) begin
            src[2] = 32'(i * 16);
            sel = 3'd2;
            pc_write = 1'b1;
            step();
            exp_cnt = (exp_cnt < 3) ? exp_cnt + 1 : 3;
            exp_pc  = 32'(i * 16);
            check("sat_loop_pc", pc_out, exp_pc);
            check("sat_loop_cnt", 32'(commit_cnt), 32'(exp_cnt));
        end
        idle_inputs();
        step();
        check("final_commit", 32'(commit), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
